ebr_resolve_ctrl: RTL
=====================

// Module: ebr_resolve_ctrl
// PURPOSE
//  Branch-resolution controller for the EBR snapshot file. Mirrors EBR slot allocation, collects
//  branch-unit outcomes and retires them strictly oldest-first. A correct branch drives a one-cycle
//  up (slot release); a mispredict drives one-cycle early_flush plus a fetch redirect.
//  Also produces ebr_full, which stalls rename when every snapshot slot is taken.
// PARAMETERS
//  EBR_NUM    4   snapshot slots; power of two, >=2; matches EBR
//  ROB_DEPTH  16  ROB entries; tag width TW = $clog2(ROB_DEPTH)+1
// PORTS
//  clk             in   1        clock
//  rst             in   1        reset, asynchronous, active-high
//  snap            in   1        branch renamed this cycle; same pulse that EBR receives
//  snap_tag        in   TW       ROB tag of that branch
//  br_valid        in   1        branch unit result valid
//  br_tag          in   TW       ROB tag of the resolved branch
//  br_mispredict   in   1        resolved direction/target differs from prediction
//  br_target       in   32       correct next PC
//  ebr_full        out  1        all EBR_NUM slots occupied; rename must hold branches
//  up              out  1        oldest slot resolved correct; release EBR_recovery_idx
//  early_flush     out  1        oldest slot mispredicted; flush EBR/ROB/RS/free list
//  EBR_recovery_idx out $clog2(EBR_NUM)  slot named by up/early_flush
//  redirect_valid  out  1        fetch redirect; equals early_flush
//  redirect_pc     out  32       br_target stored in the flushed slot
// BEHAVIOUR
//  State per slot: valid, tag, done, mis, target. Pointers: alloc_ptr, head_ptr (wrap modulo EBR_NUM).
//  Counter: cnt (0..EBR_NUM). ebr_full = (cnt==EBR_NUM).
//  FSM: RUN, BLANK. Reset: RUN, all slots invalid, pointers 0, cnt 0.
//  Reset outputs: all 0. rst takes effect mid-operation and discards pending results.
//  Alloc: snap in RUN and not full -> slot[alloc_ptr] = {valid=1, tag=snap_tag, done=0}; alloc_ptr++.
//   snap while full is ignored (no state change). snap is ignored in BLANK and in any early_flush cycle.
//  Resolve: br_valid in RUN -> CAM br_tag against valid, !done slots. On hit: done=1, mis, target latched.
//   A miss (squashed branch) is ignored. At most one match; the bench never resolves a branch
//   in its own snap cycle.
//  Retire: outputs are combinational from registered slot state; they are evaluated on slot[head_ptr] only.
//   Head valid&done&!mis -> up=1, idx=head_ptr. At the clock edge: slot invalid, head_ptr++, cnt--.
//   Head valid&done&mis -> early_flush=redirect_valid=1, idx=head_ptr, redirect_pc=target.
//    At the clock edge: all slots invalid, both pointers=0, cnt=0, FSM->BLANK. EBR also clears on this pulse.
//   A younger slot that is done but not at head waits. A younger mispredict waits for all older slots.
//   If an older slot then mispredicts, the younger result is discarded.
//  Latency: br_valid at cycle N with the slot at head -> up/early_flush in cycle N+1.
//   Only one up or early_flush per cycle.
//  BLANK: exactly one cycle. In BLANK, br_valid and snap are ignored and all outputs are 0. Next state: RUN.
//  Simultaneous events in RUN:
//   snap with up -> cnt unchanged.
//   br_valid resolving slot X while up retires the head -> both take effect.
//   early_flush wins over snap and br_valid in the same cycle.
//  Wrap: pointers roll EBR_NUM-1 -> 0. The CAM ignores ordering. Age is defined by distance from head_ptr.
//  up and early_flush are mutually exclusive by construction. The verification bench asserts this.
// TESTING
//  1. rst; snap tags 3,4 -> cnt=2; br(3,ok) at N -> up=1, idx=0 at N+1; br(4,ok) -> up, idx=1.
//  2. Fill slots with tags 1..4 -> ebr_full=1; 5th snap ignored; br(1,ok) -> up, then full drops to 0 next cycle.
//  3. Slots with tags 5,6; br(6,mis,0x80) first -> no output; br(5,ok) -> up idx0, then next cycle early_flush idx1, redirect_pc=0x80.
//  4. Slots with tags 5,6; br(6,mis) then br(5,mis,0x40) -> one early_flush idx0 pc=0x40; tag 6 discarded; BLANK, then cnt=0.
//  5. early_flush cycle with snap and br_valid asserted -> both dropped; BLANK cycle snap dropped; RUN snap allocs idx0.
//  6. Run 6 alloc/retire pairs -> idx wraps 3->0 correctly; assert rst mid-run -> all outputs 0 and cnt=0 immediately.

Source files
------------

// File: rtl/ebr_resolve_ctrl.sv
// ebr_resolve_ctrl
//   Branch-resolution controller for the EBR snapshot file. It tracks which
//   snapshot slots hold an outstanding branch and records branch-unit
//   outcomes. Outcomes retire strictly oldest-first:
//     - a correct branch releases its slot with a one-cycle 'up' pulse;
//     - a mispredict raises a one-cycle 'early_flush' and a fetch redirect.
//   It also raises 'ebr_full' while every slot is occupied.
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   snap, snap_tag    branch renamed this cycle and its ROB tag
//   br_valid, br_tag  branch-unit result and the tag it refers to
//   br_mispredict     the resolved branch was mispredicted
//   br_target         correct next PC for the resolved branch
//   ebr_full          all snapshot slots occupied
//   up                head slot resolved correct; release EBR_recovery_idx
//   early_flush       head slot mispredicted; flush everything younger
//   EBR_recovery_idx  slot named by up / early_flush
//   redirect_valid    fetch redirect (same pulse as early_flush)
//   redirect_pc       target stored in the flushed slot
module ebr_resolve_ctrl #(
  parameter int EBR_NUM   = 4,
  parameter int ROB_DEPTH = 16,
  localparam int TW = $clog2(ROB_DEPTH) + 1,
  localparam int IW = $clog2(EBR_NUM),
  localparam int CW = $clog2(EBR_NUM + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          snap,
  input  logic [TW-1:0] snap_tag,
  input  logic          br_valid,
  input  logic [TW-1:0] br_tag,
  input  logic          br_mispredict,
  input  logic [31:0]   br_target,
  output logic          ebr_full,
  output logic          up,
  output logic          early_flush,
  output logic [IW-1:0] EBR_recovery_idx,
  output logic          redirect_valid,
  output logic [31:0]   redirect_pc
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t              state_r;
  logic [EBR_NUM-1:0]  valid_r;
  logic [EBR_NUM-1:0]  done_r;
  logic [EBR_NUM-1:0]  mis_r;
  logic [TW-1:0]       tag_r    [EBR_NUM];
  logic [31:0]         target_r [EBR_NUM];
  logic [IW-1:0]       alloc_ptr_r;
  logic [IW-1:0]       head_ptr_r;
  logic [CW-1:0]       cnt_r;

  logic                run_s;
  logic                head_ready_s;
  logic                up_s;
  logic                flush_s;
  logic                alloc_s;
  logic                resolve_s;
  logic [EBR_NUM-1:0]  hit_s;

  // Retire decision looks only at the head slot; BLANK suppresses all outputs.
  always_comb begin
    run_s        = (state_r == RUN);
    head_ready_s = run_s && valid_r[head_ptr_r] && done_r[head_ptr_r];
    up_s         = head_ready_s && !mis_r[head_ptr_r];
    flush_s      = head_ready_s && mis_r[head_ptr_r];
    // A flush discards any snap or result arriving in the same cycle.
    alloc_s      = snap && run_s && !ebr_full && !flush_s;
    resolve_s    = br_valid && run_s && !flush_s;
  end

  // Tag CAM over outstanding (valid, not yet done) slots; order does not matter.
  always_comb begin
    hit_s = {EBR_NUM{1'b0}};
    for (int i = 0; i < EBR_NUM; i++) begin
      if (valid_r[i] && !done_r[i] && (tag_r[i] == br_tag)) begin
        hit_s[i] = 1'b1;
      end else begin
        hit_s[i] = 1'b0;
      end
    end
  end

  // Output decode from registered slot state.
  always_comb begin
    ebr_full         = (cnt_r == CW'(EBR_NUM));
    up               = up_s;
    early_flush      = flush_s;
    redirect_valid   = flush_s;
    EBR_recovery_idx = (up_s || flush_s) ? head_ptr_r : {IW{1'b0}};
    redirect_pc      = flush_s ? target_r[head_ptr_r] : 32'h0000_0000;
  end

  // FSM plus slot file, pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= RUN;
      valid_r     <= {EBR_NUM{1'b0}};
      done_r      <= {EBR_NUM{1'b0}};
      mis_r       <= {EBR_NUM{1'b0}};
      alloc_ptr_r <= {IW{1'b0}};
      head_ptr_r  <= {IW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      for (int i = 0; i < EBR_NUM; i++) begin
        tag_r[i]    <= {TW{1'b0}};
        target_r[i] <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (flush_s) begin
            valid_r     <= {EBR_NUM{1'b0}};
            done_r      <= {EBR_NUM{1'b0}};
            mis_r       <= {EBR_NUM{1'b0}};
            alloc_ptr_r <= {IW{1'b0}};
            head_ptr_r  <= {IW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            state_r     <= BLANK;
          end else begin
            if (resolve_s) begin
              for (int i = 0; i < EBR_NUM; i++) begin
                if (hit_s[i]) begin
                  done_r[i]   <= 1'b1;
                  mis_r[i]    <= br_mispredict;
                  target_r[i] <= br_target;
                end
              end
            end
            // Allocation lands on an invalid slot, so it never collides with
            // the slot being released or resolved.
            if (alloc_s) begin
              valid_r[alloc_ptr_r] <= 1'b1;
              done_r[alloc_ptr_r]  <= 1'b0;
              mis_r[alloc_ptr_r]   <= 1'b0;
              tag_r[alloc_ptr_r]   <= snap_tag;
              alloc_ptr_r          <= alloc_ptr_r + 1'b1;
            end
            if (up_s) begin
              valid_r[head_ptr_r] <= 1'b0;
              head_ptr_r          <= head_ptr_r + 1'b1;
            end
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, alloc_s} - {{(CW-1){1'b0}}, up_s};
          end
        end
        BLANK: begin
          state_r <= RUN;
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

endmodule
